// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module : sb_cfg_pkg
// Brief  : Shared types and constants for the switchbox configuration loader.
// Rev    : 1.0
// ============================================================================
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } cfg_state_t;

    localparam logic OP_WRITE    = 1'b0;
    localparam logic OP_VERIFY   = 1'b1;

    localparam int   SB_CFG_BITS = 256;

endpackage : sb_cfg_pkg
`default_nettype wire

// File: rtl/sb_cfg_piso.sv
`default_nettype none
// ============================================================================
// Module : sb_cfg_piso
// Brief  : Word buffer with MSB-first bit index; supports load, shift, flush.
// Rev    : 1.0
// ============================================================================
module sb_cfg_piso #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_shift,
    input  logic              i_flush,
    output logic              o_bit,
    output logic              o_empty,
    output logic              o_last_bit
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;

    // Load has priority over shift so a new word can follow the last bit with no bubble.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_buf   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_idx   <= IDX_W'(WORD_W - 1);
            r_valid <= 1'b1;
        end else if (i_shift && r_valid) begin
            if (r_idx == '0) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx - IDX_W'(1);
            end
        end
    end

    assign o_bit      = r_buf[r_idx];
    assign o_empty    = !r_valid;
    assign o_last_bit = r_valid && (r_idx == '0);

endmodule : sb_cfg_piso
`default_nettype wire

// File: rtl/sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module : sb_config_loader
// Brief  : Serializes host words into the switchbox config chain; verify mode rotates and compares.
// Rev    : 1.0
// ============================================================================
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int CHAIN_BITS = SB_CFG_BITS,
    parameter int WORD_W     = 32,
    parameter int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              op_verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_out,
    output logic              cfg_en,
    input  logic              cfg_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_count
);

    localparam int NWORDS = CHAIN_BITS / WORD_W;
    localparam int WCNT_W = $clog2(NWORDS + 1);

    generate
        if ((CHAIN_BITS % WORD_W) != 0) begin : g_bad_chain_len
            $fatal(1, "sb_config_loader: CHAIN_BITS must be a multiple of WORD_W");
        end
    endgenerate

    cfg_state_t        r_state;
    cfg_state_t        w_next_state;
    logic              r_op;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WCNT_W-1:0] r_words_left;
    logic              r_error;
    logic [CNT_W-1:0]  r_err_count;

    logic w_start_acc;
    logic w_accept;
    logic w_bit;
    logic w_empty;
    logic w_last_bit;
    logic w_shift_en;
    logic w_last_chain;
    logic w_mismatch;

    assign w_start_acc  = (r_state == IDLE) && start && !abort;
    assign w_shift_en   = (r_state == SHIFT) && !w_empty;
    assign word_ready   = (r_state == SHIFT) && (w_empty || w_last_bit) && (r_words_left != '0);
    assign w_accept     = word_valid && word_ready;
    assign w_last_chain = w_shift_en && (r_bit_cnt == CNT_W'(CHAIN_BITS - 1));
    assign w_mismatch   = w_shift_en && (r_op == OP_VERIFY) && (cfg_in != w_bit);

    sb_cfg_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk        (clk),
        .nrst       (nrst),
        .i_load     (w_accept),
        .i_data     (word_data),
        .i_shift    (w_shift_en),
        .i_flush    (abort),
        .o_bit      (w_bit),
        .o_empty    (w_empty),
        .o_last_bit (w_last_bit)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_acc)  w_next_state = SHIFT;
            SHIFT:   if (w_last_chain) w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (abort) begin
            w_next_state = IDLE;
        end
    end

    // Error state survives abort so the host can inspect a partial verify.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_op         <= OP_WRITE;
            r_bit_cnt    <= '0;
            r_words_left <= '0;
            r_error      <= 1'b0;
            r_err_count  <= '0;
        end else if (w_start_acc) begin
            r_op         <= op_verify;
            r_bit_cnt    <= '0;
            r_words_left <= WCNT_W'(NWORDS);
            r_error      <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_words_left <= r_words_left - WCNT_W'(1);
            end
            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != {CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end

    // Verify feeds the tail straight back to the head so the chain rotates intact.
    assign cfg_out   = ((r_state == SHIFT) && (r_op == OP_VERIFY)) ? cfg_in : (w_shift_en & w_bit);
    assign cfg_en    = w_shift_en;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH) && !abort;
    assign error     = r_error;
    assign err_count = r_err_count;

endmodule : sb_config_loader
`default_nettype wire
